// File: rtl/rocc_mem_arbiter.sv
// rtl/rocc_mem_arbiter.sv - two-client round-robin arbiter for the shared RoCC memory port
// Client ID rides in the tag MSB; responses are routed back by that bit.
module rocc_mem_arbiter #(
  parameter int coreMaxAddrBits  = 40,
  parameter int coreDataBits     = 64,
  parameter int dcacheReqTagBits = 8,
  parameter int M_SZ             = 5,
  parameter int MAX_OUTSTANDING  = 4
) (
  input  logic                          clock,
  input  logic                          reset,

  input  logic                          c0_req_valid,
  output logic                          c0_req_ready,
  input  logic [coreMaxAddrBits-1:0]    c0_req_addr,
  input  logic [dcacheReqTagBits-2:0]   c0_req_tag,
  input  logic [M_SZ-1:0]               c0_req_cmd,
  input  logic [1:0]                    c0_req_size,
  input  logic [coreDataBits-1:0]       c0_req_data,
  input  logic [coreDataBits/8-1:0]     c0_req_mask,
  output logic                          c0_resp_valid,
  output logic [dcacheReqTagBits-2:0]   c0_resp_tag,
  output logic [coreDataBits-1:0]       c0_resp_data,
  output logic                          c0_resp_has_data,

  input  logic                          c1_req_valid,
  output logic                          c1_req_ready,
  input  logic [coreMaxAddrBits-1:0]    c1_req_addr,
  input  logic [dcacheReqTagBits-2:0]   c1_req_tag,
  input  logic [M_SZ-1:0]               c1_req_cmd,
  input  logic [1:0]                    c1_req_size,
  input  logic [coreDataBits-1:0]       c1_req_data,
  input  logic [coreDataBits/8-1:0]     c1_req_mask,
  output logic                          c1_resp_valid,
  output logic [dcacheReqTagBits-2:0]   c1_resp_tag,
  output logic [coreDataBits-1:0]       c1_resp_data,
  output logic                          c1_resp_has_data,

  output logic                          mem_req_valid,
  input  logic                          mem_req_ready,
  output logic [coreMaxAddrBits-1:0]    mem_req_addr,
  output logic [dcacheReqTagBits-1:0]   mem_req_tag,
  output logic [M_SZ-1:0]               mem_req_cmd,
  output logic [1:0]                    mem_req_size,
  output logic [coreDataBits-1:0]       mem_req_data,
  output logic [coreDataBits/8-1:0]     mem_req_mask,
  output logic                          mem_req_phys,
  output logic                          mem_req_signed,

  input  logic                          mem_resp_valid,
  input  logic [dcacheReqTagBits-1:0]   mem_resp_tag,
  input  logic [coreDataBits-1:0]       mem_resp_data,
  input  logic                          mem_resp_has_data,

  output logic                          busy,
  output logic                          err
);

  localparam int TW = dcacheReqTagBits;
  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUTSTANDING);

  logic [CW-1:0] cnt [2];
  logic          last_grant;
  logic          can_load;
  logic [1:0]    elig;
  logic [1:0]    grant;
  logic [1:0]    resp;

  assign can_load = !mem_req_valid || mem_req_ready;
  assign elig[0]  = c0_req_valid && (cnt[0] < MAX_CNT);
  assign elig[1]  = c1_req_valid && (cnt[1] < MAX_CNT);

  // On a tie the client that did not win last time goes next.
  assign grant[0] = can_load && elig[0] && (!elig[1] || last_grant);
  assign grant[1] = can_load && elig[1] && (!elig[0] || !last_grant);

  assign c0_req_ready = grant[0];
  assign c1_req_ready = grant[1];

  assign resp[0] = mem_resp_valid && !mem_resp_tag[TW-1];
  assign resp[1] = mem_resp_valid &&  mem_resp_tag[TW-1];

  assign c0_resp_valid    = resp[0];
  assign c0_resp_tag      = mem_resp_tag[TW-2:0];
  assign c0_resp_data     = mem_resp_data;
  assign c0_resp_has_data = mem_resp_has_data;
  assign c1_resp_valid    = resp[1];
  assign c1_resp_tag      = mem_resp_tag[TW-2:0];
  assign c1_resp_data     = mem_resp_data;
  assign c1_resp_has_data = mem_resp_has_data;

  assign mem_req_phys   = 1'b0;
  assign mem_req_signed = 1'b0;

  assign busy = mem_req_valid || (cnt[0] != '0) || (cnt[1] != '0);

  always_ff @(posedge clock) begin
    if (reset) begin
      mem_req_valid <= 1'b0;
      mem_req_addr  <= '0;
      mem_req_tag   <= '0;
      mem_req_cmd   <= '0;
      mem_req_size  <= '0;
      mem_req_data  <= '0;
      mem_req_mask  <= '0;
      last_grant    <= 1'b1;
    end else if (grant[1]) begin
      mem_req_valid <= 1'b1;
      mem_req_addr  <= c1_req_addr;
      mem_req_tag   <= {1'b1, c1_req_tag};
      mem_req_cmd   <= c1_req_cmd;
      mem_req_size  <= c1_req_size;
      mem_req_data  <= c1_req_data;
      mem_req_mask  <= c1_req_mask;
      last_grant    <= 1'b1;
    end else if (grant[0]) begin
      mem_req_valid <= 1'b1;
      mem_req_addr  <= c0_req_addr;
      mem_req_tag   <= {1'b0, c0_req_tag};
      mem_req_cmd   <= c0_req_cmd;
      mem_req_size  <= c0_req_size;
      mem_req_data  <= c0_req_data;
      mem_req_mask  <= c0_req_mask;
      last_grant    <= 1'b0;
    end else if (mem_req_ready) begin
      mem_req_valid <= 1'b0;
    end
  end

  // A response with nothing outstanding is flagged and never underflows the count.
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt[0] <= '0;
      cnt[1] <= '0;
      err    <= 1'b0;
    end else begin
      for (int n = 0; n < 2; n++) begin
        if (resp[n] && (cnt[n] == '0)) begin
          err <= 1'b1;
        end
        if (grant[n] && !resp[n]) begin
          cnt[n] <= cnt[n] + CW'(1);
        end else if (!grant[n] && resp[n] && (cnt[n] != '0)) begin
          cnt[n] <= cnt[n] - CW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_rocc_mem_arbiter.sv
// tb/tb_rocc_mem_arbiter.sv - scoreboard bench for rocc_mem_arbiter
module tb_rocc_mem_arbiter;

  localparam int AW = 40;
  localparam int DW = 64;
  localparam int TW = 8;
  localparam int SW = 5;
  localparam int MW = DW / 8;

  logic          clock = 1'b0;
  logic          reset = 1'b1;

  logic          c0_req_valid = 1'b0, c0_req_ready;
  logic [AW-1:0] c0_req_addr = '0;
  logic [TW-2:0] c0_req_tag = '0;
  logic [SW-1:0] c0_req_cmd = '0;
  logic [1:0]    c0_req_size = '0;
  logic [DW-1:0] c0_req_data = '0;
  logic [MW-1:0] c0_req_mask = '0;
  logic          c0_resp_valid, c0_resp_has_data;
  logic [TW-2:0] c0_resp_tag;
  logic [DW-1:0] c0_resp_data;

  logic          c1_req_valid = 1'b0, c1_req_ready;
  logic [AW-1:0] c1_req_addr = '0;
  logic [TW-2:0] c1_req_tag = '0;
  logic [SW-1:0] c1_req_cmd = '0;
  logic [1:0]    c1_req_size = '0;
  logic [DW-1:0] c1_req_data = '0;
  logic [MW-1:0] c1_req_mask = '0;
  logic          c1_resp_valid, c1_resp_has_data;
  logic [TW-2:0] c1_resp_tag;
  logic [DW-1:0] c1_resp_data;

  logic          mem_req_valid, mem_req_phys, mem_req_signed;
  logic          mem_req_ready = 1'b0;
  logic [AW-1:0] mem_req_addr;
  logic [TW-1:0] mem_req_tag;
  logic [SW-1:0] mem_req_cmd;
  logic [1:0]    mem_req_size;
  logic [DW-1:0] mem_req_data;
  logic [MW-1:0] mem_req_mask;

  logic          mem_resp_valid = 1'b0;
  logic [TW-1:0] mem_resp_tag = '0;
  logic [DW-1:0] mem_resp_data = '0;
  logic          mem_resp_has_data = 1'b0;

  logic          busy, err;

  rocc_mem_arbiter dut (
    .clock(clock), .reset(reset),
    .c0_req_valid(c0_req_valid), .c0_req_ready(c0_req_ready), .c0_req_addr(c0_req_addr),
    .c0_req_tag(c0_req_tag), .c0_req_cmd(c0_req_cmd), .c0_req_size(c0_req_size),
    .c0_req_data(c0_req_data), .c0_req_mask(c0_req_mask),
    .c0_resp_valid(c0_resp_valid), .c0_resp_tag(c0_resp_tag), .c0_resp_data(c0_resp_data),
    .c0_resp_has_data(c0_resp_has_data),
    .c1_req_valid(c1_req_valid), .c1_req_ready(c1_req_ready), .c1_req_addr(c1_req_addr),
    .c1_req_tag(c1_req_tag), .c1_req_cmd(c1_req_cmd), .c1_req_size(c1_req_size),
    .c1_req_data(c1_req_data), .c1_req_mask(c1_req_mask),
    .c1_resp_valid(c1_resp_valid), .c1_resp_tag(c1_resp_tag), .c1_resp_data(c1_resp_data),
    .c1_resp_has_data(c1_resp_has_data),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_req_tag(mem_req_tag), .mem_req_cmd(mem_req_cmd), .mem_req_size(mem_req_size),
    .mem_req_data(mem_req_data), .mem_req_mask(mem_req_mask),
    .mem_req_phys(mem_req_phys), .mem_req_signed(mem_req_signed),
    .mem_resp_valid(mem_resp_valid), .mem_resp_tag(mem_resp_tag), .mem_resp_data(mem_resp_data),
    .mem_resp_has_data(mem_resp_has_data),
    .busy(busy), .err(err)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [TW-1:0] tag;
    logic [SW-1:0] cmd;
    logic [1:0]    size;
    logic [DW-1:0] data;
    logic [MW-1:0] mask;
  } req_t;

  typedef struct packed {
    logic          v0;
    logic          v1;
    logic [TW-2:0] tag;
    logic [DW-1:0] data;
    logic          has;
  } rsp_t;

  req_t exp_q[$];
  rsp_t rsp_q[$];
  req_t mon_e, mon_a, mon_p;
  rsp_t rsp_e, rsp_a;
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic drive_c0(input logic v, input logic [AW-1:0] a, input logic [TW-2:0] t);
    c0_req_valid = v;
    c0_req_addr  = a;
    c0_req_tag   = t;
    c0_req_cmd   = 5'd0;
    c0_req_size  = 2'd3;
    c0_req_data  = {a[31:0], 25'h0, t};
    c0_req_mask  = 8'hff;
  endtask

  task automatic drive_c1(input logic v, input logic [AW-1:0] a, input logic [TW-2:0] t);
    c1_req_valid = v;
    c1_req_addr  = a;
    c1_req_tag   = t;
    c1_req_cmd   = 5'd1;
    c1_req_size  = 2'd2;
    c1_req_data  = {~a[31:0], 25'h1, t};
    c1_req_mask  = {1'b0, t};
  endtask

  task automatic set_resp(input logic v, input logic [TW-1:0] t, input logic [DW-1:0] d,
                          input logic h);
    rsp_t r;
    mem_resp_valid    = v;
    mem_resp_tag      = t;
    mem_resp_data     = d;
    mem_resp_has_data = h;
    if (v) begin
      r.v0   = !t[TW-1];
      r.v1   = t[TW-1];
      r.tag  = t[TW-2:0];
      r.data = d;
      r.has  = h;
      rsp_q.push_back(r);
    end
  endtask

  // Scoreboard: client fires push, memory-side fires and responses pop.
  always @(negedge clock) begin
    if (!reset) begin
      if (mem_req_valid && mem_req_ready) begin
        n_tests++;
        mon_a = {mem_req_addr, mem_req_tag, mem_req_cmd, mem_req_size, mem_req_data, mem_req_mask};
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL mem_req_unexpected: got %h, expected no request", mon_a);
        end else begin
          mon_e = exp_q.pop_front();
          if (mon_a !== mon_e) begin
            n_fail++;
            $display("FAIL mem_req_fields: got %h, expected %h", mon_a, mon_e);
          end
        end
      end
      n_tests++;
      if (c0_req_ready && c1_req_ready) begin
        n_fail++;
        $display("FAIL ready_onehot: got c0=%b c1=%b, expected at most one", c0_req_ready, c1_req_ready);
      end
      if (c0_req_valid && c0_req_ready) begin
        mon_p = {c0_req_addr, 1'b0, c0_req_tag, c0_req_cmd, c0_req_size, c0_req_data, c0_req_mask};
        exp_q.push_back(mon_p);
      end
      if (c1_req_valid && c1_req_ready) begin
        mon_p = {c1_req_addr, 1'b1, c1_req_tag, c1_req_cmd, c1_req_size, c1_req_data, c1_req_mask};
        exp_q.push_back(mon_p);
      end
      if (mem_resp_valid) begin
        n_tests++;
        if (rsp_q.size() == 0) begin
          n_fail++;
          $display("FAIL resp_unexpected: got tag %h, expected no response", mem_resp_tag);
        end else begin
          rsp_e = rsp_q.pop_front();
          rsp_a.v0   = c0_resp_valid;
          rsp_a.v1   = c1_resp_valid;
          rsp_a.tag  = rsp_e.v1 ? c1_resp_tag : c0_resp_tag;
          rsp_a.data = rsp_e.v1 ? c1_resp_data : c0_resp_data;
          rsp_a.has  = rsp_e.v1 ? c1_resp_has_data : c0_resp_has_data;
          if (rsp_a !== rsp_e) begin
            n_fail++;
            $display("FAIL resp_route: got %h, expected %h", rsp_a, rsp_e);
          end
        end
      end
    end
  end

  task automatic test_reset;
    repeat (3) tick;
    n_tests++;
    if ({mem_req_valid, busy, err, mem_req_phys, mem_req_signed} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_flags: got v/busy/err/phys/signed=%b, expected 00000",
               {mem_req_valid, busy, err, mem_req_phys, mem_req_signed});
    end
    n_tests++;
    if ({mem_req_addr, mem_req_tag, mem_req_data} !== '0) begin
      n_fail++;
      $display("FAIL reset_fields: got addr=%h tag=%h data=%h, expected zeros",
               mem_req_addr, mem_req_tag, mem_req_data);
    end
    reset = 1'b0;
    mem_req_ready = 1'b1;
  endtask

  task automatic test_contention;
    for (int i = 0; i < 6; i++) begin
      drive_c0(1'b1, 40'h1000 + 40'(i), 7'(i));
      drive_c1(1'b1, 40'h2000 + 40'(i), 7'(i));
      #1;
      n_tests++;
      if (c0_req_ready !== (i % 2 == 0) || c1_req_ready !== (i % 2 == 1)) begin
        n_fail++;
        $display("FAIL contention_grant[%0d]: got c0=%b c1=%b, expected c0=%b", i,
                 c0_req_ready, c1_req_ready, (i % 2 == 0));
      end
      tick;
      n_tests++;
      if (mem_req_valid !== 1'b1 || mem_req_tag[TW-1] !== 1'(i % 2)) begin
        n_fail++;
        $display("FAIL contention_tag_msb[%0d]: got valid=%b msb=%b, expected 1 and %0d", i,
                 mem_req_valid, mem_req_tag[TW-1], i % 2);
      end
    end
    drive_c0(1'b0, '0, '0);
    drive_c1(1'b0, '0, '0);
    tick;
    for (int j = 0; j < 6; j++) begin
      set_resp(1'b1, {1'(j % 2), 7'(j)}, 64'(j * 3), 1'b1);
      tick;
    end
    set_resp(1'b0, '0, '0, 1'b0);
    n_tests++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL contention_drain_busy: got %b, expected 0", busy);
    end
  endtask

  task automatic test_single_load;
    drive_c0(1'b1, 40'h100, 7'h05);
    #1;
    n_tests++;
    if (c0_req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL single_c0_ready: got %b, expected 1", c0_req_ready);
    end
    tick;
    drive_c0(1'b0, '0, '0);
    n_tests++;
    if (mem_req_valid !== 1'b1 || mem_req_addr !== 40'h100 || mem_req_tag !== 8'h05 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL single_issue: got v=%b addr=%h tag=%h busy=%b, expected 1 100 05 1",
               mem_req_valid, mem_req_addr, mem_req_tag, busy);
    end
    tick;
    set_resp(1'b1, 8'h05, 64'h1, 1'b1);
    #1;
    n_tests++;
    if (c0_resp_valid !== 1'b1 || c0_resp_tag !== 7'h05 || c0_resp_data !== 64'h1 || c1_resp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL single_resp: got c0v=%b tag=%h data=%h c1v=%b, expected 1 05 1 0",
               c0_resp_valid, c0_resp_tag, c0_resp_data, c1_resp_valid);
    end
    tick;
    set_resp(1'b0, '0, '0, 1'b0);
    n_tests++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL single_busy_clear: got %b, expected 0", busy);
    end
  endtask

  task automatic test_backpressure;
    mem_req_ready = 1'b0;
    drive_c0(1'b1, 40'h300, 7'h11);
    #1;
    n_tests++;
    if (c0_req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_first_ready: got %b, expected 1", c0_req_ready);
    end
    tick;
    drive_c0(1'b1, 40'h308, 7'h12);
    drive_c1(1'b1, 40'h400, 7'h22);
    for (int k = 0; k < 5; k++) begin
      #1;
      n_tests++;
      if (c0_req_ready !== 1'b0 || c1_req_ready !== 1'b0 || mem_req_valid !== 1'b1 ||
          mem_req_addr !== 40'h300 || mem_req_tag !== 8'h11) begin
        n_fail++;
        $display("FAIL bp_hold[%0d]: got r0=%b r1=%b v=%b addr=%h tag=%h, expected 0 0 1 300 11", k,
                 c0_req_ready, c1_req_ready, mem_req_valid, mem_req_addr, mem_req_tag);
      end
      tick;
    end
    mem_req_ready = 1'b1;
    #1;
    n_tests++;
    if (c1_req_ready !== 1'b1 || c0_req_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_release_grant: got c0=%b c1=%b, expected c0=0 c1=1", c0_req_ready, c1_req_ready);
    end
    tick;
    drive_c1(1'b0, '0, '0);
    n_tests++;
    if (mem_req_tag !== 8'hA2 || mem_req_addr !== 40'h400) begin
      n_fail++;
      $display("FAIL bp_next_issue: got tag=%h addr=%h, expected a2 400", mem_req_tag, mem_req_addr);
    end
    #1;
    n_tests++;
    if (c0_req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_c0_second: got %b, expected 1", c0_req_ready);
    end
    tick;
    drive_c0(1'b0, '0, '0);
    tick;
    set_resp(1'b1, 8'h11, 64'h11, 1'b1);
    tick;
    set_resp(1'b1, 8'h12, 64'h12, 1'b1);
    tick;
    set_resp(1'b1, 8'hA2, 64'h0, 1'b0);
    tick;
    set_resp(1'b0, '0, '0, 1'b0);
    n_tests++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_drain_busy: got %b, expected 0", busy);
    end
  endtask

  task automatic test_throttle;
    for (int k = 0; k < 4; k++) begin
      drive_c0(1'b1, 40'h500 + 40'(k * 8), 7'(k));
      #1;
      n_tests++;
      if (c0_req_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL throttle_issue[%0d]: got %b, expected 1", k, c0_req_ready);
      end
      tick;
    end
    drive_c0(1'b1, 40'h520, 7'h04);
    #1;
    n_tests++;
    if (c0_req_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL throttle_blocked: got %b, expected 0", c0_req_ready);
    end
    drive_c1(1'b1, 40'h600, 7'h30);
    #1;
    n_tests++;
    if (c1_req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL throttle_c1_passes: got %b, expected 1", c1_req_ready);
    end
    tick;
    drive_c1(1'b0, '0, '0);
    set_resp(1'b1, 8'h02, 64'hdead, 1'b1);
    #1;
    n_tests++;
    if (c0_req_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL throttle_resp_cycle: got %b, expected 0", c0_req_ready);
    end
    tick;
    set_resp(1'b0, '0, '0, 1'b0);
    #1;
    n_tests++;
    if (c0_req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL throttle_reenable: got %b, expected 1", c0_req_ready);
    end
    tick;
    drive_c0(1'b0, '0, '0);
    tick;
    set_resp(1'b1, 8'h00, 64'h0, 1'b1);
    tick;
    set_resp(1'b1, 8'h01, 64'h1, 1'b1);
    tick;
    set_resp(1'b1, 8'h03, 64'h3, 1'b1);
    tick;
    set_resp(1'b1, 8'h04, 64'h4, 1'b1);
    tick;
    set_resp(1'b1, 8'hB0, 64'h0, 1'b0);
    tick;
    set_resp(1'b0, '0, '0, 1'b0);
    n_tests++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL throttle_drain_busy: got %b, expected 0", busy);
    end
  endtask

  task automatic test_fire_and_resp;
    int issued;
    drive_c1(1'b1, 40'h700, 7'h40);
    tick;
    drive_c1(1'b1, 40'h708, 7'h41);
    tick;
    drive_c1(1'b1, 40'h710, 7'h42);
    set_resp(1'b1, 8'hC0, 64'h7, 1'b0);
    #1;
    n_tests++;
    if (c1_req_ready !== 1'b1 || c1_resp_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL same_cycle_setup: got ready=%b resp=%b, expected 1 1", c1_req_ready, c1_resp_valid);
    end
    tick;
    set_resp(1'b0, '0, '0, 1'b0);
    issued = 0;
    for (int k = 0; k < 4; k++) begin
      drive_c1(1'b1, 40'h720 + 40'(k * 8), 7'(8'h50 + k));
      #1;
      if (c1_req_ready !== 1'b1) break;
      issued++;
      tick;
    end
    drive_c1(1'b0, '0, '0);
    n_tests++;
    if (issued !== 2) begin
      n_fail++;
      $display("FAIL same_cycle_cnt: got %0d more issues before throttle, expected 2", issued);
    end
    tick;
    set_resp(1'b1, 8'hC1, 64'h1, 1'b0);
    tick;
    set_resp(1'b1, 8'hC2, 64'h2, 1'b0);
    tick;
    for (int k = 0; k < issued; k++) begin
      set_resp(1'b1, {1'b1, 7'(8'h50 + k)}, 64'(k), 1'b0);
      tick;
    end
    set_resp(1'b0, '0, '0, 1'b0);
    n_tests++;
    if (busy !== 1'b0 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL same_cycle_drain: got busy=%b err=%b, expected 0 0", busy, err);
    end
    set_resp(1'b1, 8'h81, 64'h0, 1'b0);
    tick;
    set_resp(1'b0, '0, '0, 1'b0);
    n_tests++;
    if (err !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL spurious_resp: got err=%b busy=%b, expected 1 0", err, busy);
    end
    repeat (3) tick;
    n_tests++;
    if (err !== 1'b1) begin
      n_fail++;
      $display("FAIL err_sticky: got %b, expected 1", err);
    end
  endtask

  task automatic test_reset_midflight;
    drive_c0(1'b1, 40'h800, 7'h60);
    tick;
    drive_c0(1'b1, 40'h808, 7'h61);
    tick;
    drive_c0(1'b1, 40'h810, 7'h62);
    tick;
    drive_c0(1'b0, '0, '0);
    mem_req_ready = 1'b0;
    tick;
    n_tests++;
    if (mem_req_valid !== 1'b1 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL midflight_setup: got v=%b busy=%b, expected 1 1", mem_req_valid, busy);
    end
    reset = 1'b1;
    mem_resp_valid = 1'b1;
    mem_resp_tag   = 8'h60;
    tick;
    exp_q.delete();
    n_tests++;
    if (mem_req_valid !== 1'b0 || busy !== 1'b0 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL midflight_reset: got v=%b busy=%b err=%b, expected 0 0 0", mem_req_valid, busy, err);
    end
    reset = 1'b0;
    mem_resp_valid = 1'b0;
    mem_req_ready = 1'b1;
    tick;
    n_tests++;
    if (err !== 1'b0) begin
      n_fail++;
      $display("FAIL resp_during_reset: got err=%b, expected 0", err);
    end
    set_resp(1'b1, 8'h61, 64'h1, 1'b1);
    tick;
    set_resp(1'b0, '0, '0, 1'b0);
    n_tests++;
    if (err !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL late_resp_err: got err=%b busy=%b, expected 1 0", err, busy);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_contention();
    test_single_load();
    test_backpressure();
    test_throttle();
    test_fire_and_resp();
    test_reset_midflight();
    tick;
    n_tests++;
    if (exp_q.size() != 0 || rsp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_leftover: got req=%0d resp=%0d entries, expected 0 0",
               exp_q.size(), rsp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rocc_mem_arbiter.md
# rocc_mem_arbiter

Two-client arbiter that shares the accelerator's single `rocc_mem_req` / `rocc_mem_resp` port between a load engine (client 0) and a store engine (client 1) inside `Asic`.
- Requests are registered into a one-entry output slot and granted round-robin.
- The client ID is tagged into the tag MSB, and responses are routed back by tag.
- Per-client outstanding transactions are counted and throttled.
- `busy` tells the command FSM when all memory traffic has drained, so it can issue the RoCC response.

## Interface
Parameters:
- `coreMaxAddrBits`, 40, request address width
- `coreDataBits`, 64, data width
- `dcacheReqTagBits`, 8, memory tag width; the MSB carries the client ID
- `M_SZ`, 5, memory command width
- `MAX_OUTSTANDING`, 4, per-client in-flight limit (≥1, ≤ 2^(dcacheReqTagBits-1))

Ports:
- `clock` in 1: single clock, rising edge
- `reset` in 1: synchronous, active-high
- `cN_req_valid` in 1, `cN_req_ready` out 1 (N = 0, 1): client request handshake
- `cN_req_addr` in coreMaxAddrBits
- `cN_req_tag` in dcacheReqTagBits-1: client-local tag
- `cN_req_cmd` in M_SZ
- `cN_req_size` in 2
- `cN_req_data` in coreDataBits
- `cN_req_mask` in coreDataBits/8
- `cN_resp_valid` out 1, `cN_resp_tag` out dcacheReqTagBits-1, `cN_resp_data` out coreDataBits, `cN_resp_has_data` out 1: routed response
- `mem_req_valid` out 1, `mem_req_ready` in 1
- `mem_req_addr`/`tag`/`cmd`/`size`/`data`/`mask` out: matching widths; `mem_req_phys` out 1 (tied 0); `mem_req_signed` out 1 (tied 0)
- `mem_resp_valid` in 1, `mem_resp_tag` in dcacheReqTagBits, `mem_resp_data` in coreDataBits, `mem_resp_has_data` in 1
- `busy` out 1: any request in the slot or in flight
- `err` out 1: sticky flag for an unexpected response

## Operation
Output slot:
- One registered entry holds all `mem_req_*` fields plus `mem_req_valid`.
- The slot can load on a cycle when it is empty, or when `mem_req_valid && mem_req_ready` (fire).

Eligibility and grant:
- Client N is eligible when `cN_req_valid` is high and `cnt[N] < MAX_OUTSTANDING`.
- When the slot can load:
  - One eligible client: it is granted.
  - Both eligible: grant goes to `!last_grant`.
- `cN_req_ready` is high only for the granted client, is combinational, and is at most one-hot.

On client fire:
- The slot loads the client's fields, with `mem_req_tag = {N, cN_req_tag}`.
- `last_grant <= N` and `cnt[N]++`.
- While the slot is full and `mem_req_ready` is low, slot contents are held stable (valid/ready rule) and both readies are 0.

Response routing:
- Routing is combinational. `cN_resp_valid = mem_resp_valid && mem_resp_tag[MSB] == N`.
- `cN_resp_tag` is the low tag bits; data and has_data pass through.
- Responses cannot be back-pressured, and responses with has_data=0 (store acks) are routed the same way.
- On a routed response, `cnt[N]--`.

Counter rules:
- If `cnt[N] == 0` when a response arrives for N: the counter stays 0 and `err` sets. `err` clears only on reset.
- Client fire and response for the same client in the same cycle: `cnt` unchanged.

`busy = mem_req_valid | (cnt[0] != 0) | (cnt[1] != 0)`.

## Timing
- Reset values: `mem_req_valid` 0, all `mem_req_*` fields 0, `cnt` 0, `last_grant` 1 (client 0 wins the first tie), `err` 0, `busy` 0.
- Reset asserted mid-operation drops the slot and counters next edge. Responses arriving after reset are flagged as `err` only if they arrive after reset deassertion.
- Request latency: client fire at edge k puts `mem_req_valid` high after edge k. A client can fire every cycle while `mem_req_ready` stays high (full throughput, no bubble).
- Response latency: zero cycles, from `mem_resp_valid` to `cN_resp_valid` in the same cycle.
- Throttling: at `cnt[N] == MAX_OUTSTANDING`, `cN_req_ready` is 0 until the response cycle. A response on cycle k re-enables the client's ready in cycle k+1.

## Test plan
- Single load: c0 sends addr 0x100, tag 0x05. Required: after one edge, `mem_req_valid=1`, addr 0x100, tag 0x05; `busy=1`. ExtMem responds with tag 0x05, data 0x1: `c0_resp_valid=1`, tag 0x05, data 0x1; `c1_resp_valid=0`; `busy=0` next cycle.
- Contention: both clients valid every cycle, `mem_req_ready=1`. Required: grant order c0, c1, c0, c1…; tags out carry MSB 0, 1, 0, 1.
- Backpressure: hold `mem_req_ready=0` for 5 cycles with the slot full. Required: slot fields are stable, both readies are 0, and c1's request is issued right after c0's fires.
- Throttle: c0 issues 4 requests with no responses. Required: `c0_req_ready=0` while c1 still issues. Send a response with tag 0x02: c0 is ready again on the following cycle.
- Simultaneous fire and response on c1 with `cnt[1]=2`: required `cnt[1]` stays 2. A spurious response with tag 0x81 when `cnt[1]=0`: required `err=1`, held until reset, and `cnt` stays 0.
- Reset mid-flight with `cnt[0]=3` and the slot full: required next cycle `mem_req_valid=0`, `busy=0`, `err=0`.
